// File: rtl/uart_receiver_if.sv
// Receiver-side bus: serial line and frame configuration in, received byte and status out.
interface uart_receiver_if;
    logic       rx;
    logic       d_num;
    logic       s_num;
    logic [1:0] par;
    logic [7:0] data_out;
    logic       r_done;
    logic       par_err;
    logic       frame_err;
    logic       busy;

    modport master (
        output rx, d_num, s_num, par,
        input  data_out, r_done, par_err, frame_err, busy
    );

    modport slave (
        input  rx, d_num, s_num, par,
        output data_out, r_done, par_err, frame_err, busy
    );
endinterface

// File: rtl/uart_receiver.sv
// Purpose: oversampling UART receiver (7/8 data bits, optional parity, 1/2 stop bits); optional macro UART_RX_MAJORITY_VOTE_EN.
// Latency: r_done 2 + OVERSAMPLE/2 + N*OVERSAMPLE + 1 cycles after the rx falling edge (+1 with majority vote).
// Backpressure: none; the consumer must take data_out on the r_done pulse, outputs hold until the next frame.
module uart_receiver #(
    parameter int OVERSAMPLE = 16
) (
    input  logic           clk_rx,
    input  logic           reset,
    uart_receiver_if.slave bus
);
    localparam int CW = (OVERSAMPLE > 2) ? $clog2(OVERSAMPLE) : 1;
`ifdef UART_RX_MAJORITY_VOTE_EN
    localparam int VOTE = 1;
`else
    localparam int VOTE = 0;
`endif
    localparam logic [CW-1:0] TICK_MID = CW'(OVERSAMPLE / 2 - 1 + VOTE);
    localparam logic [CW-1:0] TICK_BIT = CW'(OVERSAMPLE - 1);

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

    state_t        state;
    logic          rx_m;
    logic          rx_s;
    logic [CW-1:0] tick;
    logic [2:0]    pos;
    logic [7:0]    sh;
    logic          cfg_d;
    logic          cfg_s;
    logic [1:0]    cfg_par;
    logic          pe_int;
    logic          fe_int;
    logic          stop2;
    logic          armed;
    logic [7:0]    data_q;
    logic          r_done_q;
    logic          par_err_q;
    logic          frame_err_q;
    logic          busy_q;
    logic          bit_val;
    logic          par_en;
    logic          par_calc;

`ifdef UART_RX_MAJORITY_VOTE_EN
    logic rx_h1;
    logic rx_h2;

    always_ff @(posedge clk_rx) begin
        if (!reset) begin
            rx_h1 <= 1'b1;
            rx_h2 <= 1'b1;
        end else begin
            rx_h1 <= rx_s;
            rx_h2 <= rx_h1;
        end
    end

    // Decision tick is mid+1, so rx_s/rx_h1/rx_h2 are the mid+1/mid/mid-1 samples.
    assign bit_val = (rx_s & rx_h1) | (rx_s & rx_h2) | (rx_h1 & rx_h2);
`else
    assign bit_val = rx_s;
`endif

    assign par_en   = (cfg_par == 2'b01) || (cfg_par == 2'b10);
    // sh[7] stays 0 in 7-bit mode, so one reduction covers both widths.
    assign par_calc = ^sh;

    always_ff @(posedge clk_rx) begin
        if (!reset) begin
            state       <= IDLE;
            rx_m        <= 1'b1;
            rx_s        <= 1'b1;
            tick        <= '0;
            pos         <= '0;
            sh          <= '0;
            cfg_d       <= 1'b0;
            cfg_s       <= 1'b0;
            cfg_par     <= 2'b00;
            pe_int      <= 1'b0;
            fe_int      <= 1'b0;
            stop2       <= 1'b0;
            armed       <= 1'b1;
            data_q      <= '0;
            r_done_q    <= 1'b0;
            par_err_q   <= 1'b0;
            frame_err_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            rx_m     <= bus.rx;
            rx_s     <= rx_m;
            r_done_q <= 1'b0;
            case (state)
                IDLE: begin
                    tick <= '0;
                    if (rx_s) begin
                        armed <= 1'b1;
                    end else if (armed) begin
                        state   <= START;
                        busy_q  <= 1'b1;
                        cfg_d   <= bus.d_num;
                        cfg_s   <= bus.s_num;
                        cfg_par <= bus.par;
                        sh      <= '0;
                        pos     <= '0;
                        pe_int  <= 1'b0;
                        fe_int  <= 1'b0;
                        stop2   <= 1'b0;
                    end
                end
                START: begin
                    if (tick == TICK_MID) begin
                        tick <= '0;
                        if (bit_val) begin
                            state  <= IDLE;
                            busy_q <= 1'b0;
                        end else begin
                            state <= DATA;
                        end
                    end else begin
                        tick <= tick + 1'b1;
                    end
                end
                DATA: begin
                    if (tick == TICK_BIT) begin
                        tick    <= '0;
                        sh[pos] <= bit_val;
                        pos     <= pos + 1'b1;
                        if (pos == {2'b11, cfg_d})
                            state <= par_en ? PARITY : STOP;
                    end else begin
                        tick <= tick + 1'b1;
                    end
                end
                PARITY: begin
                    if (tick == TICK_BIT) begin
                        tick   <= '0;
                        state  <= STOP;
                        pe_int <= (cfg_par == 2'b10) ? (bit_val ^ par_calc) : ~(bit_val ^ par_calc);
                    end else begin
                        tick <= tick + 1'b1;
                    end
                end
                STOP: begin
                    if (tick == TICK_BIT) begin
                        tick <= '0;
                        if (!bit_val)
                            fe_int <= 1'b1;
                        if (cfg_s && !stop2) begin
                            stop2 <= 1'b1;
                        end else begin
                            // Back to IDLE at mid-stop so an immediate next start edge is caught;
                            // a low stop disarms detection until the line returns high.
                            state       <= IDLE;
                            busy_q      <= 1'b0;
                            r_done_q    <= 1'b1;
                            data_q      <= sh;
                            par_err_q   <= pe_int;
                            frame_err_q <= fe_int | ~bit_val;
                            armed       <= bit_val;
                        end
                    end else begin
                        tick <= tick + 1'b1;
                    end
                end
                default: begin
                    state  <= IDLE;
                    busy_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.data_out  = data_q;
    assign bus.r_done    = r_done_q;
    assign bus.par_err   = par_err_q;
    assign bus.frame_err = frame_err_q;
    assign bus.busy      = busy_q;
endmodule

// File: tb/tb_uart_receiver.sv
// Bench for uart_receiver: table of frames plus hand-written corner sequences, scoreboard checked on r_done.
module tb_uart_receiver;
    localparam int OS = 16;
`ifdef UART_RX_MAJORITY_VOTE_EN
    localparam int VOTE = 1;
`else
    localparam int VOTE = 0;
`endif

    typedef struct {
        logic [7:0] dat;
        logic       pe;
        logic       fe;
        int         cyc;
    } exp_t;

    typedef struct {
        logic       d;
        logic       s;
        logic [1:0] p;
        logic [7:0] dat;
        logic       pbit;
        logic       stop;
        logic [7:0] exp_dat;
        logic       exp_pe;
        logic       exp_fe;
    } vec_t;

    logic clk_rx = 1'b0;
    logic reset;
    int   cyc = 0;
    int   total = 0;
    int   bad = 0;
    exp_t sb[$];
    exp_t mon_e;
    logic prev_done = 1'b0;
    vec_t vecs[10];

    uart_receiver_if bus_if();

    uart_receiver #(.OVERSAMPLE(OS)) dut (
        .clk_rx (clk_rx),
        .reset  (reset),
        .bus    (bus_if)
    );

    always #5 clk_rx = ~clk_rx;
    always @(posedge clk_rx) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h, required %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Scoreboard consumer: every r_done must match the oldest expected frame.
    always @(negedge clk_rx) begin
        if (bus_if.r_done === 1'b1) begin
            check("r_done_single_cycle", {31'd0, prev_done}, 32'd0);
            if (sb.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_r_done: got a pulse at cycle %0d, required none", cyc);
            end else begin
                mon_e = sb.pop_front();
                check("data_out", {24'd0, bus_if.data_out}, {24'd0, mon_e.dat});
                check("par_err", {31'd0, bus_if.par_err}, {31'd0, mon_e.pe});
                check("frame_err", {31'd0, bus_if.frame_err}, {31'd0, mon_e.fe});
                check("busy_at_done", {31'd0, bus_if.busy}, 32'd0);
                check("latency_cycle", cyc, mon_e.cyc);
            end
        end
        prev_done <= bus_if.r_done;
    end

    task automatic drive_bit(input logic v);
        bus_if.rx = v;
        repeat (OS) @(negedge clk_rx);
    endtask

    task automatic idle(input int n);
        bus_if.rx = 1'b1;
        repeat (n) @(negedge clk_rx);
    endtask

    task automatic push_exp(input logic [7:0] dat, input logic pe, input logic fe, input int n_bits, input int start);
        exp_t e;
        e.dat = dat;
        e.pe  = pe;
        e.fe  = fe;
        e.cyc = start + 3 + OS / 2 + n_bits * OS + VOTE;
        sb.push_back(e);
    endtask

    task automatic send_frame(input logic d, input logic s, input logic [1:0] p, input logic [7:0] dat,
                              input logic pbit, input logic stop,
                              input logic [7:0] exp_dat, input logic exp_pe, input logic exp_fe);
        int  n;
        logic has_par;
        has_par = (p == 2'b01) || (p == 2'b10);
        n = (d ? 8 : 7) + (has_par ? 1 : 0) + (s ? 2 : 1);
        bus_if.d_num = d;
        bus_if.s_num = s;
        bus_if.par   = p;
        push_exp(exp_dat, exp_pe, exp_fe, n, cyc);
        drive_bit(1'b0);
        check("busy_mid_frame", {31'd0, bus_if.busy}, 32'd1);
        // Config is latched at start detection; scrambling it now must not matter.
        bus_if.d_num = ~d;
        bus_if.s_num = ~s;
        bus_if.par   = ~p;
        for (int i = 0; i < (d ? 8 : 7); i++) drive_bit(dat[i]);
        if (has_par) drive_bit(pbit);
        drive_bit(stop);
        if (s) drive_bit(1'b1);
    endtask

    task automatic wait_drain(input int budget);
        for (int i = 0; i < budget && sb.size() != 0; i++) @(negedge clk_rx);
        total++;
        if (sb.size() != 0) begin
            bad++;
            $display("FAIL drain_timeout: got %0d frames outstanding, required 0", sb.size());
            sb.delete();
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time, required completion");
        $fatal(1);
    end

    initial begin
        int start;
        vecs[0] = '{1'b1, 1'b0, 2'b00, 8'hA5, 1'b0, 1'b1, 8'hA5, 1'b0, 1'b0};
        vecs[1] = '{1'b0, 1'b1, 2'b10, 8'h53, 1'b0, 1'b1, 8'h53, 1'b0, 1'b0};
        vecs[2] = '{1'b0, 1'b1, 2'b10, 8'h53, 1'b1, 1'b1, 8'h53, 1'b1, 1'b0};
        vecs[3] = '{1'b1, 1'b0, 2'b01, 8'hFF, 1'b1, 1'b1, 8'hFF, 1'b0, 1'b0};
        vecs[4] = '{1'b1, 1'b0, 2'b01, 8'h00, 1'b1, 1'b0, 8'h00, 1'b0, 1'b1};
        vecs[5] = '{1'b0, 1'b0, 2'b00, 8'hD5, 1'b0, 1'b1, 8'h55, 1'b0, 1'b0};
        vecs[6] = '{1'b1, 1'b0, 2'b10, 8'h01, 1'b1, 1'b1, 8'h01, 1'b0, 1'b0};
        vecs[7] = '{1'b1, 1'b1, 2'b10, 8'h7E, 1'b1, 1'b1, 8'h7E, 1'b1, 1'b0};
        vecs[8] = '{1'b0, 1'b0, 2'b01, 8'h00, 1'b0, 1'b1, 8'h00, 1'b1, 1'b0};
        vecs[9] = '{1'b1, 1'b0, 2'b11, 8'h3C, 1'b0, 1'b1, 8'h3C, 1'b0, 1'b0};

        reset        = 1'b0;
        bus_if.rx    = 1'b1;
        bus_if.d_num = 1'b1;
        bus_if.s_num = 1'b0;
        bus_if.par   = 2'b00;
        repeat (3) @(negedge clk_rx);
        check("rst_data_out", {24'd0, bus_if.data_out}, 32'd0);
        check("rst_r_done", {31'd0, bus_if.r_done}, 32'd0);
        check("rst_par_err", {31'd0, bus_if.par_err}, 32'd0);
        check("rst_frame_err", {31'd0, bus_if.frame_err}, 32'd0);
        check("rst_busy", {31'd0, bus_if.busy}, 32'd0);
        reset = 1'b1;
        idle(4);

        for (int v = 0; v < 10; v++) begin
            send_frame(vecs[v].d, vecs[v].s, vecs[v].p, vecs[v].dat, vecs[v].pbit, vecs[v].stop,
                       vecs[v].exp_dat, vecs[v].exp_pe, vecs[v].exp_fe);
            idle(OS);
        end
        wait_drain(4 * OS);

        // Short low glitch: false start, no r_done, held outputs untouched.
        bus_if.rx = 1'b0;
        repeat (4) @(negedge clk_rx);
        check("glitch_busy_high", {31'd0, bus_if.busy}, 32'd1);
        @(negedge clk_rx);
        idle(OS);
        check("glitch_busy_low", {31'd0, bus_if.busy}, 32'd0);
        check("glitch_data_held", {24'd0, bus_if.data_out}, 32'h3C);

        // Back-to-back 8N1 frames, no idle gap.
        send_frame(1'b1, 1'b0, 2'b00, 8'h3C, 1'b0, 1'b1, 8'h3C, 1'b0, 1'b0);
        send_frame(1'b1, 1'b0, 2'b00, 8'hC3, 1'b0, 1'b1, 8'hC3, 1'b0, 1'b0);
        idle(OS);
        wait_drain(4 * OS);

        // Break: line low far beyond a frame -> one zero frame with frame_err, no retrigger.
        bus_if.d_num = 1'b1;
        bus_if.s_num = 1'b0;
        bus_if.par   = 2'b00;
        push_exp(8'h00, 1'b0, 1'b1, 9, cyc);
        bus_if.rx = 1'b0;
        repeat (12 * OS) @(negedge clk_rx);
        idle(2 * OS);
        wait_drain(4 * OS);
        send_frame(1'b1, 1'b0, 2'b00, 8'h5A, 1'b0, 1'b1, 8'h5A, 1'b0, 1'b0);
        idle(OS);
        wait_drain(4 * OS);

        // Reset in the middle of the data bits of 0x81, then a clean 0x81.
        bus_if.d_num = 1'b1;
        bus_if.s_num = 1'b0;
        bus_if.par   = 2'b00;
        drive_bit(1'b0);
        drive_bit(1'b1);
        drive_bit(1'b0);
        bus_if.rx = 1'b0;
        repeat (OS / 2) @(negedge clk_rx);
        check("abort_busy_before_reset", {31'd0, bus_if.busy}, 32'd1);
        reset     = 1'b0;
        bus_if.rx = 1'b1;
        repeat (3) @(negedge clk_rx);
        check("abort_data_out", {24'd0, bus_if.data_out}, 32'd0);
        check("abort_busy", {31'd0, bus_if.busy}, 32'd0);
        check("abort_par_err", {31'd0, bus_if.par_err}, 32'd0);
        check("abort_frame_err", {31'd0, bus_if.frame_err}, 32'd0);
        reset = 1'b1;
        idle(2 * OS);
        send_frame(1'b1, 1'b0, 2'b00, 8'h81, 1'b0, 1'b1, 8'h81, 1'b0, 1'b0);
        idle(2 * OS);
        wait_drain(4 * OS);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/uart_receiver.md
Name: uart_receiver

Overview:
- Serial-to-parallel UART receive end: the counterpart of the team's UART transmitter, sharing its frame format and configuration encodings.
- Oversamples the `rx` line, detects the start bit, samples data, parity and stop bits at mid-bit, and presents the byte with error flags.
- Sits between the external `rx` pin and the host-side consumer.
- `clk_rx` runs at OVERSAMPLE x baud rate.

Parameters:
- OVERSAMPLE, 16: `clk_rx` cycles per bit period. Must be even and >= 4. Sample counter width is `$clog2(OVERSAMPLE)`.

Ports:
- clk_rx  input  1  receive clock, OVERSAMPLE x baud
- reset  input  1  synchronous, active-low reset (asserted when 0, sampled on posedge `clk_rx`)
- rx  input  1  asynchronous serial line, idle high
- d_num  input  1  0: 7 data bits, 1: 8 data bits
- s_num  input  1  0: 1 stop bit, 1: 2 stop bits
- par  input  2  00 none, 01 odd, 10 even, 11 treated as none
- data_out  output  8  received byte; bit 7 forced 0 in 7-bit mode
- r_done  output  1  one-cycle pulse: frame complete, `data_out`/flags updated
- par_err  output  1  parity mismatch on the last frame
- frame_err  output  1  a stop bit sampled low on the last frame
- busy  output  1  high from start-bit detection until return to IDLE

Behaviour:
- Single clock domain: all logic on posedge `clk_rx`.
- Reset (reset==0, synchronous):
  - state=IDLE; counters cleared.
  - Synchronizer flops set to 1.
  - `data_out`=0, `r_done`=0, `par_err`=0, `frame_err`=0, `busy`=0.
  - Reset mid-frame aborts the frame: no `r_done`, outputs return to reset values.
- Input sync: `rx` passes through 2 flops (`rx_s`). All decisions use `rx_s`.
- Configuration: `d_num`/`s_num`/`par` are captured at start-bit detection. Changes mid-frame are ignored.
- Frame format: LSB first. Optional parity bit follows the data bits.
- Parity rule:
  - even: parity bit must equal XOR of the data bits.
  - odd: parity bit must equal XNOR of the data bits.
  - 7-bit mode uses bits [6:0] only.
- State machine: IDLE -> START -> DATA -> (PARITY) -> STOP -> IDLE.
  - IDLE: `busy`=0. On `rx_s`==0, go to START with tick counter=0; `busy`=1 from the next cycle.
  - START: count to OVERSAMPLE/2-1, then sample `rx_s`.
    - Sample 1: false start; return to IDLE, no `r_done`, flags unchanged.
    - Sample 0: go to DATA with tick counter cleared.
  - DATA: sample every OVERSAMPLE ticks (mid-bit) into shift position `pos`. After bit 6 (d_num=0) or bit 7 (d_num=1), go to PARITY if par is 01/10, else to STOP.
  - PARITY: sample once after OVERSAMPLE ticks; compute mismatch into an internal flag.
  - STOP: sample after OVERSAMPLE ticks.
    - Any 0 sets the internal frame error.
    - If s_num=1, sample a second stop bit OVERSAMPLE ticks later.
    - After the final stop sample, in the same cycle: return to IDLE.
    - Next cycle: `r_done`=1 for one cycle, with `data_out`, `par_err` and `frame_err` updated together.
- Frame error: `data_out` is still updated; `frame_err`=1.
- Back-to-back frames: IDLE is entered at the mid-point of the last stop bit, so a start edge arriving immediately after the stop bit is detected.
- Held outputs: `data_out`, `par_err` and `frame_err` hold until the next `r_done`.
- Line held low (break):
  - Decoded as a frame of zeros with `frame_err`=1.
  - Receiver then waits in IDLE for `rx_s`==1 before arming start detection again (no re-trigger on a continuous low).
- Latency: `r_done` rises 2 (sync) + OVERSAMPLE/2 + N x OVERSAMPLE + 1 cycles after the `rx` falling edge. N = data bits + parity bits + stop bits.

Optional Feature:
- Macro: `UART_RX_MAJORITY_VOTE_EN`.
- Defined: each bit value (start, data, parity, stop) is the 2-of-3 majority of `rx_s` at ticks mid-1, mid and mid+1. Decision timing is unchanged; the bit resolves at tick mid+1, and latency increases by 1 cycle. A single-cycle glitch at mid-bit is rejected.
- Undefined: a single sample at tick mid, as specified above.

Test Plan:
- Frame 8N1 with byte 0xA5, OVERSAMPLE=16 -> `r_done` pulse; `data_out`=0xA5; `par_err`=0; `frame_err`=0; `busy` falls when `r_done` rises.
- Frame 7E2 with byte 0x53 and parity bit 0 -> `data_out`=0x53, `par_err`=0. Repeat with parity bit 1 -> `par_err`=1.
- Frame 8O1 with byte 0xFF and correct parity bit 1 -> `par_err`=0. Then 0x00 with stop bit 0 -> `data_out`=0x00, `frame_err`=1.
- `rx` low for 5 cycles only (glitch shorter than OVERSAMPLE/2) -> false start; no `r_done`; `busy` returns to 0.
- Two back-to-back 8N1 frames 0x3C then 0xC3 with no idle gap -> two `r_done` pulses with correct bytes in order.
- reset=0 asserted mid-DATA, then a full frame 0x81 -> no `r_done` for the aborted frame; outputs 0 after reset; subsequent `data_out`=0x81.
